// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SCAN  = 2'd2
    } scan_state_e;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment pattern, seg[6]=a .. seg[0]=g.
module hex_to_7seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        unique case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Define SEG7_SCAN_LZB_EN to blank leading zeros (digit 0 is always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_CYC  = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int VAL_W   = 4 * NUM_DIGITS;
    localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DIG_END = CNT_W'(DIGIT_CYC - 1);
    localparam logic [CNT_W-1:0] BLK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [VAL_W-1:0]        disp_q, disp_d;
    logic [VAL_W-1:0]        pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    ready_q, ready_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    enter_slot0;
    logic                    digit_dark;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        enter_slot0 = 1'b0;

        if (upd_valid && !pend_full_q) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end

        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    idx_d       = '0;
                    cnt_d       = '0;
                    enter_slot0 = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLK_END) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == DIG_END) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_END) begin
                            idx_d       = '0;
                            enter_slot0 = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        // Pending value reaches the display only at the start of a frame, so a frame never tears.
        if (enter_slot0 && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        ready_d = !pend_full_d;
    end

    assign nibble = disp_d[4*idx_d +: 4];

    hex_to_7seg u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    // Outputs are computed from next-state values so they register on the same edge as state.
    always_comb begin
`ifdef SEG7_SCAN_LZB_EN
        digit_dark = (idx_d != '0) && ((disp_d >> (4 * idx_d)) == '0);
`else
        digit_dark = 1'b0;
`endif
        seg_d        = SEG_OFF;
        an_d         = '1;
        frame_tick_d = (state_d == SCAN) && (idx_d == IDX_END) && (cnt_d == DIG_END);
        if (state_d == SCAN && !digit_dark) begin
            seg_d       = dec_seg;
            an_d[idx_d] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            ready_q      <= ready_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign upd_ready  = ready_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
